// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the UART register write path and the serial transmitter.
// Stores CPU writes and launches them one at a time with a one-cycle tx_dv pulse.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              ovf_clr,
    input  logic              tx_active,
    input  logic              tx_done,
    output logic              tx_dv,
    output logic [7:0]        tx_byte,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [7:0]          mem_r [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_r;
    logic [ADDR_W-1:0]   rd_ptr_r;
    logic [ADDR_W:0]     count_r;
    logic [ADDR_W:0]     count_nxt_s;
    logic                full_r;
    logic                empty_r;
    logic                tx_dv_r;
    logic [7:0]          tx_byte_r;
    logic                overflow_r;
    logic                push_s;
    logic                pop_s;
    logic                drop_s;

    // Push/pop qualification and next occupancy; full is the start-of-cycle value.
    always_comb begin
        push_s      = wr_en & ~full_r;
        drop_s      = wr_en & full_r;
        pop_s       = (state_r == IDLE) & ~empty_r & ~tx_active;
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + (ADDR_W + 1)'(1);
            2'b01:   count_nxt_s = count_r - (ADDR_W + 1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Launch sequencer; tx_dv_r high marks the launch cycle, whose tx_done is stale.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (pop_s) begin
                    state_nxt_s = WAIT_DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_DONE: begin
                if (tx_done && !tx_dv_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, pointers, occupancy flags and the registered transmitter interface.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            tx_dv_r    <= 1'b0;
            tx_byte_r  <= 8'h00;
            overflow_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == FULL_CNT);
            empty_r <= (count_nxt_s == '0);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r  <= rd_ptr_r + ADDR_W'(1);
                tx_byte_r <= mem_r[rd_ptr_r];
                tx_dv_r   <= 1'b1;
            end else begin
                tx_dv_r   <= 1'b0;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign tx_dv    = tx_dv_r;
    assign tx_byte  = tx_byte_r;
    assign full     = full_r;
    assign empty    = empty_r;
    assign count    = count_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, transmitter model with
// serial decoder, and a launch scoreboard.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       ovf_clr;
    logic       tx_active;
    logic       tx_done;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] ser_q[$];
    logic       sb_en    = 1'b0;
    logic       model_en = 1'b0;
    logic       busy     = 1'b0;
    logic       ser_line = 1'b1;
    logic       prev_dv  = 1'b0;
    logic [9:0] shreg;
    int         clkcnt;
    int         bitcnt;

    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .ovf_clr(ovf_clr),
        .tx_active(tx_active), .tx_done(tx_done), .tx_dv(tx_dv), .tx_byte(tx_byte),
        .full(full), .empty(empty), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       clr;
        logic       act;
        logic       done;
        logic       e_dv;
        logic [7:0] e_byte;
        logic [4:0] e_cnt;
        logic       e_empty;
        logic       e_full;
        logic       e_ovf;
    } vec_t;

    vec_t vt[15];

    function automatic vec_t mk(input logic wr, input logic [7:0] data, input logic act,
                                input logic done, input logic dv, input logic [7:0] b,
                                input logic [4:0] c, input logic clr);
        vec_t v;
        v.wr = wr; v.data = data; v.clr = clr; v.act = act; v.done = done;
        v.e_dv = dv; v.e_byte = b; v.e_cnt = c;
        v.e_empty = (c == 5'd0); v.e_full = (c == 5'd16); v.e_ovf = 1'b0;
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic drive_push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        if (sb_en) begin
            exp_q.push_back(b);
            ser_q.push_back(b);
        end
    endtask

    task automatic model_off();
        model_en  = 1'b0;
        tx_done   = 1'b0;
        tx_active = 1'b0;
    endtask

    task automatic sb_on();
        exp_q.delete();
        ser_q.delete();
        sb_en = 1'b1;
    endtask

    task automatic wait_drain(input string nm);
        bit ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (exp_q.size() == 0 && ser_q.size() == 0 && !busy && empty === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: drain timeout, got %0d launches and %0d frames pending, required 0",
                     nm, exp_q.size(), ser_q.size());
        end
    endtask

    // Serial transmitter model, 4 clocks per bit, updates on the falling edge.
    always @(negedge clk) begin
        if (model_en) begin
            tx_done = 1'b0;
            if (!busy) begin
                if (tx_dv === 1'b1) begin
                    busy      = 1'b1;
                    tx_active = 1'b1;
                    shreg     = {1'b1, tx_byte, 1'b0};
                    bitcnt    = 0;
                    clkcnt    = 0;
                    ser_line  = 1'b0;
                end
            end else begin
                clkcnt++;
                if (clkcnt == 4) begin
                    clkcnt = 0;
                    bitcnt++;
                    if (bitcnt == 10) begin
                        busy      = 1'b0;
                        tx_active = 1'b0;
                        tx_done   = 1'b1;
                        ser_line  = 1'b1;
                    end else begin
                        ser_line = shreg[bitcnt];
                    end
                end
            end
        end
    end

    // Serial decoder: samples mid-bit and checks against the expected frame order.
    always begin
        logic [7:0] d;
        logic [7:0] e;
        logic       stop;
        @(posedge clk);
        if (ser_line === 1'b0) begin
            repeat (5) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                d[i] = ser_line;
                if (i < 7) repeat (4) @(posedge clk);
            end
            repeat (4) @(posedge clk);
            stop = ser_line;
            n_cmp++;
            if (ser_q.size() == 0) begin
                n_err++;
                $display("FAIL serial: got frame %h, required no frame", d);
            end else begin
                e = ser_q.pop_front();
                if ({stop, d} !== {1'b1, e}) begin
                    n_err++;
                    $display("FAIL serial: got stop %b byte %h, required stop 1 byte %h", stop, d, e);
                end
            end
        end
    end

    // Launch scoreboard and one-cycle pulse width check.
    always @(negedge clk) begin
        logic [7:0] e;
        if (tx_dv === 1'b1) begin
            n_cmp++;
            if (prev_dv === 1'b1) begin
                n_err++;
                $display("FAIL dv_width: got tx_dv high two cycles, required one");
            end
            if (sb_en) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL launch: got tx_dv with tx_byte %h, required no launch", tx_byte);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_byte !== e) begin
                        n_err++;
                        $display("FAIL launch: got tx_byte %h, required %h", tx_byte, e);
                    end
                end
            end
        end
        prev_dv = tx_dv;
    end

    // No launch and no tx_byte change across an edge where the transmitter is busy.
    always @(posedge clk) begin
        logic       a;
        logic [7:0] b;
        a = tx_active;
        b = tx_byte;
        #1;
        if (a === 1'b1 && rst === 1'b0) begin
            n_cmp++;
            if (tx_dv !== 1'b0 || tx_byte !== b) begin
                n_err++;
                $display("FAIL busy_hold: got tx_dv %b tx_byte %h, required 0 and %h", tx_dv, tx_byte, b);
            end
        end
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0;
        tx_active = 1'b0; tx_done = 1'b0;

        vt[0]  = mk(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0);
        vt[1]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h41, 5'd0, 1'b0);
        vt[2]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h41, 5'd0, 1'b0);
        vt[3]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h41, 5'd0, 1'b0);
        vt[4]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h41, 5'd0, 1'b0);
        vt[5]  = mk(1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 8'h41, 5'd1, 1'b0);
        vt[6]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h42, 5'd0, 1'b0);
        vt[7]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h42, 5'd0, 1'b0);
        vt[8]  = mk(1'b1, 8'h43, 1'b0, 1'b0, 1'b0, 8'h42, 5'd1, 1'b0);
        vt[9]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h42, 5'd1, 1'b0);
        vt[10] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h42, 5'd1, 1'b0);
        vt[11] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h43, 5'd0, 1'b0);
        vt[12] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h43, 5'd0, 1'b0);
        vt[13] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h43, 5'd0, 1'b0);
        vt[14] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h43, 5'd0, 1'b1);

        repeat (3) tick();
        check("reset", {tx_dv, tx_byte, count, empty, full, overflow},
              {1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0});
        rst = 1'b0;
        tick();

        // Single launch latency, leftover tx_done in the launch cycle
        for (int i = 0; i < 15; i++) begin
            wr_en = vt[i].wr; wr_data = vt[i].data; ovf_clr = vt[i].clr;
            tx_active = vt[i].act; tx_done = vt[i].done;
            tick();
            check($sformatf("vec%0d", i), {tx_dv, tx_byte, count, empty, full, overflow},
                  {vt[i].e_dv, vt[i].e_byte, vt[i].e_cnt, vt[i].e_empty, vt[i].e_full, vt[i].e_ovf});
        end
        wr_en = 1'b0; ovf_clr = 1'b0; tx_active = 1'b0; tx_done = 1'b0;

        // Three back-to-back frames through the transmitter model
        sb_on();
        model_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive_push(8'(i));
            tick();
        end
        wr_en = 1'b0;
        wait_drain("frames3");

        // Fill while busy, overflow, set-wins, and pop not freeing room for a push
        model_off();
        tx_active = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive_push(8'h10 + 8'(i));
            tick();
            check($sformatf("fill_cnt%0d", i), {27'd0, count}, 32'(i + 1));
        end
        check("full_flag", {full, empty}, {1'b1, 1'b0});
        wr_data = 8'hFF;
        tick();
        check("ovf_set", {overflow, count}, {1'b1, 5'd16});
        ovf_clr = 1'b1;
        tick();
        check("ovf_set_wins", {overflow, count}, {1'b1, 5'd16});
        wr_en = 1'b0;
        tick();
        check("ovf_clr", overflow, 1'b0);
        ovf_clr = 1'b0;
        wr_en = 1'b1; wr_data = 8'hFF; tx_active = 1'b0; model_en = 1'b1;
        tick();
        check("pop_no_room", {tx_dv, count, overflow}, {1'b1, 5'd15, 1'b1});
        wr_en = 1'b0; ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        wait_drain("fill16");

        // Pointer wrap in bursts of five
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 5; j++) begin
                drive_push(8'(b * 5 + j));
                tick();
            end
            wr_en = 1'b0;
            wait_drain($sformatf("wrap_burst%0d", b));
        end

        // Simultaneous push and pop at count 3
        model_off();
        tx_active = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_push(8'hA0 + 8'(i));
            tick();
        end
        wr_en = 1'b0;
        check("pp_pre", {27'd0, count}, 32'd3);
        drive_push(8'hA3);
        tx_active = 1'b0; model_en = 1'b1;
        tick();
        check("pp_same", {tx_dv, count}, {1'b1, 5'd3});
        wr_en = 1'b0;
        wait_drain("push_pop");

        // Asynchronous reset while waiting for tx_done with five bytes stored
        model_off();
        sb_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_push(8'h60 + 8'(i));
            tick();
        end
        wr_en = 1'b0;
        check("pre_rst", {tx_dv, tx_byte, count}, {1'b0, 8'h60, 5'd5});
        #2 rst = 1'b1;
        #1 check("async_rst", {tx_dv, tx_byte, count, empty, full, overflow},
                 {1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0});
        tick();
        rst = 1'b0;
        sb_on();
        repeat (20) tick();
        check("post_rst_idle", {tx_dv, count, empty}, {1'b0, 5'd0, 1'b1});
        model_en = 1'b1;
        drive_push(8'h55);
        tick();
        wr_en = 1'b0;
        wait_drain("post_rst");

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
